// File: rtl/rr_onehot_arbiter_pkg.sv
// rr_onehot_arbiter_pkg: shared constants and state encoding for the round-robin arbiter
package rr_onehot_arbiter_pkg;
  localparam int WID_DEF      = 4;
  localparam int N_DEF        = 16;
  localparam int HOLD_WID_DEF = 8;
  localparam int MAX_HOLD_DEF = 32;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// rr_onehot_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_onehot_arbiter_if
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int WID = WID_DEF
);
  localparam int N = 2**WID;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   grant;
  logic [WID-1:0] grant_idx;
  logic           grant_valid;
  logic           timeout;
  modport master (output req, done, input grant, grant_idx, grant_valid, timeout);
  modport slave  (input req, done, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_onehot_arbiter_dec.sv
// rr_onehot_arbiter_dec: binary-to-one-hot decoder
module rr_onehot_arbiter_dec
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int WID = WID_DEF
) (
  input  logic [WID-1:0]    idx,
  output logic [2**WID-1:0] onehot
);
  assign onehot = (2**WID)'(1) << idx;
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with hold timeout, binary and one-hot grant
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int WID      = WID_DEF,
  parameter int HOLD_WID = HOLD_WID_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic               clk,
  input logic               rst,
  rr_onehot_arbiter_if.slave bus
);
  localparam int N = 2**WID;
  state_t              state;
  logic [WID-1:0]      ptr, off, sel_idx;
  logic [HOLD_WID-1:0] hold_cnt;
  logic [2*N-1:0]      dbl;
  logic [N-1:0]        sel_oh;
  logic                found, rel_done, rel_drop, rel_to;
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (dbl[i]) off = WID'(i);
    found = |bus.req;
    sel_idx = ptr + off;
    rel_done = bus.done;
    rel_drop = !bus.req[bus.grant_idx];
    rel_to = (MAX_HOLD != 0) && (hold_cnt == HOLD_WID'(MAX_HOLD));
  end
  rr_onehot_arbiter_dec #(.WID(WID)) u_dec (.idx(sel_idx), .onehot(sel_oh));
  // grant is decoded from the selected index so it registers alongside grant_idx
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_idx   <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          state           <= GRANT;
          bus.grant_idx   <= sel_idx;
          bus.grant       <= sel_oh;
          bus.grant_valid <= 1'b1;
          hold_cnt        <= HOLD_WID'(1);
        end
      end else if (rel_done || rel_drop || rel_to) begin
        state           <= IDLE;
        ptr             <= bus.grant_idx + 1'b1;
        bus.grant       <= '0;
        bus.grant_idx   <= '0;
        bus.grant_valid <= 1'b0;
        bus.timeout     <= rel_to && !rel_done && !rel_drop;
      end else begin
        hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed self-checking bench for rr_onehot_arbiter (MAX_HOLD=4)
module tb_rr_onehot_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  rr_onehot_arbiter_if #(.WID(4)) bus ();
  rr_onehot_arbiter #(.WID(4), .HOLD_WID(8), .MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic [15:0] g, input logic [3:0] idx, input logic v, input logic to);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(v));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    step();
    check_out("rst_pulse", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask
  int rot_seq [5] = '{0, 2, 15, 0, 2};
  initial begin
    bus.req = '0;
    bus.done = 1'b0;
    step();
    check_out("reset0", 16'h0, 4'd0, 1'b0, 1'b0);
    step();
    check_out("reset1", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_out("idle", 16'h0, 4'd0, 1'b0, 1'b0);
    bus.req = 16'h0008;
    step();
    check_out("single_grant", 16'h0008, 4'd3, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    check_out("single_done", 16'h0, 4'd0, 1'b0, 1'b0);
    bus.req = '0;
    step();
    check_out("done_in_idle", 16'h0, 4'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    pulse_rst();
    bus.req = 16'h8005;
    for (int i = 0; i < 5; i++) begin
      bus.done = 1'b0;
      step();
      check_out($sformatf("rot_grant%0d", i), 16'(1) << rot_seq[i], 4'(rot_seq[i]), 1'b1, 1'b0);
      bus.done = 1'b1;
      step();
      check_out($sformatf("rot_gap%0d", i), 16'h0, 4'd0, 1'b0, 1'b0);
    end
    bus.done = 1'b0;
    bus.req = '0;
    pulse_rst();
    bus.req = 16'h0002;
    step();
    check_out("to_hold1", 16'h0002, 4'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_out($sformatf("to_hold%0d", i), 16'h0002, 4'd1, 1'b1, 1'b0);
    end
    step();
    check_out("to_pulse", 16'h0, 4'd0, 1'b0, 1'b1);
    step();
    check_out("to_regrant", 16'h0002, 4'd1, 1'b1, 1'b0);
    step();
    step();
    step();
    check_out("to_regrant_hold4", 16'h0002, 4'd1, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    check_out("done_with_to", 16'h0, 4'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req = '0;
    pulse_rst();
    bus.req = 16'h0020;
    step();
    check_out("drop_grant5", 16'h0020, 4'd5, 1'b1, 1'b0);
    bus.req = 16'h0040;
    step();
    check_out("drop_release", 16'h0, 4'd0, 1'b0, 1'b0);
    step();
    check_out("drop_grant6", 16'h0040, 4'd6, 1'b1, 1'b0);
    bus.req = 16'h0240;
    step();
    check_out("other_req_ignored", 16'h0040, 4'd6, 1'b1, 1'b0);
    bus.req = '0;
    pulse_rst();
    bus.req = 16'h0200;
    step();
    check_out("mid_grant9", 16'h0200, 4'd9, 1'b1, 1'b0);
    step();
    check_out("mid_hold9", 16'h0200, 4'd9, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check_out("mid_reset", 16'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_out("mid_regrant9", 16'h0200, 4'd9, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter sharing one resource among N = 2**WID requesters.
- Grants exactly one requester at a time and holds the grant until the holder signals done, drops its request, or hits a hold timeout.
- Presents the grant both as a binary index and as a one-hot vector; the one-hot vector comes from the team's existing 4-to-16 binary-to-one-hot decoder.
- Sits in front of any shared datapath (bus, memory port) that needs serialized access.

Parameters:
- WID, 4, requester index width; N = 2**WID requesters (default 16).
- HOLD_WID, 8, width of the hold counter.
- MAX_HOLD, 8'd32, maximum consecutive grant cycles before forced release; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i = requester i.
- done  input  1  holder finished; sampled only while grant_valid=1.
- grant  output  N  one-hot grant; all zero when grant_valid=0.
- grant_idx  output  WID  binary index of the holder; 0 when grant_valid=0.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on the cycle a forced release occurs.

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs after that edge: grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Internal state: pointer=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant aborts the grant with no timeout pulse.
- All outputs are registered. grant is the decoder output of grant_idx ANDed with grant_valid.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at an edge, select the first set bit scanning pointer, pointer+1, ..., N-1, 0, ..., pointer-1 (mod N).
  - Next cycle: grant_idx=selected index, grant_valid=1, hold_cnt=1, state=GRANT.
  - Latency from req seen to grant visible: 1 clock.
  - done is ignored in IDLE.
- GRANT, release conditions, evaluated at each edge:
  - (a) done=1.
  - (b) req[grant_idx]=0.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- GRANT, on release:
  - pointer <= grant_idx+1, wrapping N-1 -> 0.
  - grant_valid <= 0, grant <= 0, grant_idx <= 0, state <= IDLE.
  - timeout <= 1 only if (c) holds and (a) and (b) do not.
- Mandatory one idle cycle between grants. A new holder is visible 2 clocks after release is sampled.
- GRANT, no release: hold_cnt increments, saturating at 2**HOLD_WID-1 when the timeout is disabled.
- Simultaneous done and timeout: normal release, timeout=0.
- req bits other than the holder's have no effect during GRANT.
- Fairness: a continuously requesting requester is granted within N grants.
- Pointer update uses WID-bit modulo arithmetic, with no explicit compare needed.

Decomposition:
- Shared package holds:
  - constants WID_DEF=4, N_DEF=16, HOLD_WID_DEF=8, MAX_HOLD_DEF=32;
  - state encoding IDLE=1'b0, GRANT=1'b1.
- Sub-module: the existing binary-to-one-hot decoder (WID -> N), instantiated once.
- Priority scan (rotate by pointer, find first set, rotate back) stays inline as a combinational block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> grant=16'h0000, grant_idx=0, grant_valid=0, timeout=0 every cycle.
- Single requester: req=16'h0008 -> one clock later grant=16'h0008, grant_idx=3, grant_valid=1. Then done=1 for one cycle -> next cycle grant_valid=0.
- Round-robin rotation:
  - req=16'h8005 held constant, done pulsed once per grant.
  - Required grant_idx sequence 0, 2, 15, 0, 2, with one idle cycle between grants.
  - Shows the wrap at 15 -> 0.
- Timeout: MAX_HOLD=4, req=16'h0002 held, done=0 -> grant_valid high exactly 4 cycles, then timeout=1 for one cycle with grant_valid=0. Regrant to idx 1 follows, since it is the only requester.
- Holder drops request: grant to idx 5, then req[5]=0 with req[6]=1 -> release with timeout=0, then grant_idx=6 two clocks after the drop.
- Reset mid-grant: grant_idx=9 active, assert rst with req=16'h0200 still set -> all outputs 0 next cycle. After rst falls, grant_idx=9 is regranted one clock later, because pointer=0 and the scan from 0 finds 9 first.
